// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C sensor target: FSM state encoding,
// default target address and the default command codes.
package i2c_pkg;

    localparam logic [6:0] I2C_ADDR_DEF = 7'h40;
    localparam logic [7:0] CMD_TEMP_DEF = 8'hE3;
    localparam logic [7:0] CMD_HUMI_DEF = 8'hE5;

    // Bit counter covers 0..8 (eight data bits plus the ACK slot decision)
    localparam int unsigned BIT_CNT_W = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_RX_CMD,
        ST_ACK_CMD,
        ST_STRETCH,
        ST_TX_MSB,
        ST_GET_ACK,
        ST_TX_LSB,
        ST_GET_NACK,
        ST_WAIT_STOP
    } state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes the raw SCL/SDA bus levels into clk, and derives SCL edges
// plus START/STOP conditions from the synchronized values.
// Ports:
//   clk, rst_n     system clock, async active-low reset
//   scl_i, sda_i   raw bus levels
//   sda_s          synchronized SDA level
//   scl_rise_c     synchronized SCL rising edge (one clk)
//   scl_fall_c     synchronized SCL falling edge (one clk)
//   start_c        SDA falling while SCL high
//   stop_c         SDA rising while SCL high
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s,
    output logic scl_rise_c,
    output logic scl_fall_c,
    output logic start_c,
    output logic stop_c
);

    logic [1:0] scl_sync_q, scl_sync_d;
    logic [1:0] sda_sync_q, sda_sync_d;
    logic       scl_prev_q, scl_prev_d;
    logic       sda_prev_q, sda_prev_d;

    // Two-flop synchronizers plus one history flop for edge detection
    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl_i};
        sda_sync_d = {sda_sync_q[0], sda_i};
        scl_prev_d = scl_sync_q[1];
        sda_prev_d = sda_sync_q[1];
    end

    // Preset to the idle-bus level so reset release never looks like a START
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign sda_s      = sda_sync_q[1];
    assign scl_rise_c =  scl_sync_q[1] & ~scl_prev_q;
    assign scl_fall_c = ~scl_sync_q[1] &  scl_prev_q;
    // SCL must be high both before and after the SDA transition
    assign start_c    =  sda_prev_q & ~sda_sync_q[1] & scl_sync_q[1] & scl_prev_q;
    assign stop_c     = ~sda_prev_q &  sda_sync_q[1] & scl_sync_q[1] & scl_prev_q;

endmodule

// File: rtl/i2c_sensor_target.sv
// I2C target emulating a humidity/temperature sensor. A write of a supported
// command byte arms a pending measurement; a following read stretches SCL for
// STRETCH_CYCLES clocks and then returns the selected 16-bit word MSB first.
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   SCL, SDA              open-drain bus lines (driven '0' or 'z' only)
//   temp_data, humi_data  words returned for CMD_TEMP / CMD_HUMI
//   cmd_valid             one-cycle pulse when a supported command is ACKed
//   cmd_code              last ACKed command byte
//   busy                  high while a transaction is in progress
module i2c_sensor_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  I2C_ADDR       = I2C_ADDR_DEF,
    parameter int unsigned STRETCH_CYCLES = 1000,
    parameter logic [7:0]  CMD_TEMP       = CMD_TEMP_DEF,
    parameter logic [7:0]  CMD_HUMI       = CMD_HUMI_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    inout  wire         SCL,
    inout  wire         SDA,
    input  logic [15:0] temp_data,
    input  logic [15:0] humi_data,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic        busy
);

    localparam int unsigned CNT_W = $clog2(STRETCH_CYCLES + 1);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [15:0]            tx_q, tx_d;
    logic                   rw_q, rw_d;
    logic                   pending_q, pending_d;
    logic                   sda_oe_q, sda_oe_d;
    logic                   scl_oe_q, scl_oe_d;
    logic [CNT_W-1:0]       stretch_cnt_q, stretch_cnt_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [7:0]             cmd_code_q, cmd_code_d;
    logic                   busy_q, busy_d;

    logic                   sda_s;
    logic                   scl_rise_c;
    logic                   scl_fall_c;
    logic                   start_c;
    logic                   stop_c;
    logic [15:0]            snap_c;

    i2c_line_sync u_line_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_i      (SCL),
        .sda_i      (SDA),
        .sda_s      (sda_s),
        .scl_rise_c (scl_rise_c),
        .scl_fall_c (scl_fall_c),
        .start_c    (start_c),
        .stop_c     (stop_c)
    );

    // Word selected by the last ACKed command
    assign snap_c = (cmd_code_q == CMD_TEMP) ? temp_data : humi_data;

    // Next-state and datapath; bus changes happen only on SCL falling edges
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        tx_d          = tx_q;
        rw_d          = rw_q;
        pending_d     = pending_q;
        sda_oe_d      = sda_oe_q;
        scl_oe_d      = scl_oe_q;
        stretch_cnt_d = stretch_cnt_q;
        cmd_valid_d   = 1'b0;
        cmd_code_d    = cmd_code_q;

        if (stop_c) begin
            state_d   = ST_IDLE;
            sda_oe_d  = 1'b0;
            scl_oe_d  = 1'b0;
            bit_cnt_d = '0;
        end else if (start_c) begin
            state_d   = ST_ADDR;
            sda_oe_d  = 1'b0;
            scl_oe_d  = 1'b0;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sda_oe_d = 1'b0;
                    scl_oe_d = 1'b0;
                end
                ST_ADDR, ST_RX_CMD: begin
                    if (scl_rise_c) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end else if (scl_fall_c && bit_cnt_q == BIT_CNT_W'(8)) begin
                        bit_cnt_d = '0;
                        if (state_q == ST_ADDR) begin
                            rw_d = shift_q[0];
                            // A read with nothing pending is refused at the address
                            if (shift_q[7:1] == I2C_ADDR && (!shift_q[0] || pending_q)) begin
                                state_d  = ST_ACK_ADDR;
                                sda_oe_d = 1'b1;
                            end else begin
                                state_d  = ST_WAIT_STOP;
                                sda_oe_d = 1'b0;
                            end
                        end else if (shift_q == CMD_TEMP || shift_q == CMD_HUMI) begin
                            state_d     = ST_ACK_CMD;
                            sda_oe_d    = 1'b1;
                            pending_d   = 1'b1;
                            cmd_valid_d = 1'b1;
                            cmd_code_d  = shift_q;
                        end else begin
                            state_d  = ST_WAIT_STOP;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_ACK_ADDR: begin
                    if (scl_fall_c) begin
                        if (rw_q) begin
                            // Snapshot and present bit 15 while SCL is held low
                            state_d       = ST_STRETCH;
                            tx_d          = snap_c;
                            sda_oe_d      = ~snap_c[15];
                            scl_oe_d      = 1'b1;
                            stretch_cnt_d = '0;
                        end else begin
                            state_d  = ST_RX_CMD;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_ACK_CMD: begin
                    if (scl_fall_c) begin
                        state_d  = ST_WAIT_STOP;
                        sda_oe_d = 1'b0;
                    end
                end
                ST_STRETCH: begin
                    if (stretch_cnt_q >= STRETCH_LAST) begin
                        state_d   = ST_TX_MSB;
                        scl_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                    end else begin
                        stretch_cnt_d = stretch_cnt_q + CNT_W'(1);
                    end
                end
                ST_TX_MSB, ST_TX_LSB: begin
                    if (scl_fall_c) begin
                        if (bit_cnt_q == BIT_CNT_W'(7)) begin
                            state_d   = (state_q == ST_TX_MSB) ? ST_GET_ACK : ST_GET_NACK;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                        end else begin
                            tx_d      = {tx_q[14:0], 1'b0};
                            sda_oe_d  = ~tx_q[14];
                            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end
                ST_GET_ACK: begin
                    if (scl_rise_c) begin
                        shift_d = {shift_q[6:0], sda_s};
                    end else if (scl_fall_c) begin
                        if (!shift_q[0]) begin
                            state_d   = ST_TX_LSB;
                            tx_d      = {tx_q[14:0], 1'b0};
                            sda_oe_d  = ~tx_q[14];
                            bit_cnt_d = '0;
                        end else begin
                            state_d  = ST_WAIT_STOP;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_GET_NACK: begin
                    if (scl_fall_c) begin
                        state_d   = ST_WAIT_STOP;
                        pending_d = 1'b0;
                        sda_oe_d  = 1'b0;
                    end
                end
                ST_WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                    scl_oe_d = 1'b0;
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                    scl_oe_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            tx_q          <= '0;
            rw_q          <= 1'b0;
            pending_q     <= 1'b0;
            sda_oe_q      <= 1'b0;
            scl_oe_q      <= 1'b0;
            stretch_cnt_q <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_code_q    <= 8'h00;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            tx_q          <= tx_d;
            rw_q          <= rw_d;
            pending_q     <= pending_d;
            sda_oe_q      <= sda_oe_d;
            scl_oe_q      <= scl_oe_d;
            stretch_cnt_q <= stretch_cnt_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_code_q    <= cmd_code_d;
            busy_q        <= busy_d;
        end
    end

    // Open-drain drivers
    assign SCL = scl_oe_q ? 1'b0 : 1'bz;
    assign SDA = sda_oe_q ? 1'b0 : 1'bz;

    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_sensor_target.sv
// Bench for i2c_sensor_target: a bit-banged I2C master drives table-driven
// write/read transactions; expected ACKs and data bytes go through a queue.
module tb_i2c_sensor_target;

    localparam int HALF = 20;
    localparam int Q    = 5;

    typedef struct {
        string       name;
        logic [7:0]  cmd;
        logic [15:0] temp;
        logic [15:0] humi;
        logic [15:0] word;
        bit          cmd_ack;
        bit          rd_ack;
        bit          m_ack_msb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] temp_data = '0;
    logic [15:0] humi_data = '0;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic        busy;
    wire         SCL;
    wire         SDA;
    logic        m_scl_rel = 1'b1;
    logic        m_sda_rel = 1'b1;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_fall = 0;
    int          last_gap = 0;
    int          cv_cnt = 0;
    logic [7:0]  cv_code = '0;
    int          sda_viol = 0;
    bit          watch = 1'b0;
    logic [7:0]  exp_code = 8'h00;
    logic [15:0] sb_q[$];
    vec_t        vecs[4];

    assign SCL = m_scl_rel ? 1'bz : 1'b0;
    assign SDA = m_sda_rel ? 1'bz : 1'b0;
    pullup (SCL);
    pullup (SDA);

    i2c_sensor_target dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SCL       (SCL),
        .SDA       (SDA),
        .temp_data (temp_data),
        .humi_data (humi_data),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmd_valid === 1'b1) begin
            cv_cnt  <= cv_cnt + 1;
            cv_code <= cmd_code;
        end
        if (watch && m_sda_rel && SDA === 1'b0) sda_viol <= sda_viol + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_range(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic sb_check(input string nm, input logic [15:0] act);
        logic [15:0] exp;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s actual=%h expected=<empty queue>", nm, act);
        end else begin
            exp = sb_q.pop_front();
            chk(nm, 32'(act), 32'(exp));
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Release SCL and wait (bounded) for the bus to go high; records the low time
    task automatic release_scl();
        int n;
        n = 0;
        m_scl_rel = 1'b1;
        while (SCL !== 1'b1 && n < 3000) begin
            wait_clk(1);
            n++;
        end
        if (SCL !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL scl_release_timeout actual=%b expected=1", SCL);
        end
        last_gap = cyc - last_fall;
    endtask

    task automatic bit_clk(input bit b, output bit s);
        m_sda_rel = b;
        wait_clk(Q);
        release_scl();
        wait_clk(HALF / 2);
        s = (SDA === 1'b1);
        wait_clk(HALF - HALF / 2);
        m_scl_rel = 1'b0;
        last_fall = cyc;
        wait_clk(HALF - Q);
    endtask

    task automatic i2c_start();
        m_sda_rel = 1'b1;
        wait_clk(Q);
        release_scl();
        wait_clk(HALF);
        m_sda_rel = 1'b0;
        wait_clk(HALF);
        m_scl_rel = 1'b0;
        last_fall = cyc;
        wait_clk(HALF - Q);
    endtask

    task automatic i2c_stop();
        m_sda_rel = 1'b0;
        wait_clk(Q);
        release_scl();
        wait_clk(HALF);
        m_sda_rel = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic write_byte(input logic [7:0] b, output bit ack);
        bit s;
        for (int i = 7; i >= 0; i--) bit_clk(b[i], s);
        bit_clk(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input bit m_ack, output logic [7:0] b, output int gap);
        bit s;
        gap = 0;
        for (int i = 7; i >= 0; i--) begin
            bit_clk(1'b1, s);
            b[i] = s;
            if (i == 7) gap = last_gap;
        end
        bit_clk(~m_ack, s);
    endtask

    task automatic run_vec(input vec_t t);
        bit         ack;
        logic [7:0] b;
        int         cv0;
        int         v0;
        int         gap;
        temp_data = t.temp;
        humi_data = t.humi;
        cv0 = cv_cnt;
        i2c_start();
        sb_q.push_back(16'd1);
        write_byte(8'h80, ack);
        sb_check({t.name, "_addr_w_ack"}, 16'(ack));
        sb_q.push_back(16'(t.cmd_ack));
        write_byte(t.cmd, ack);
        sb_check({t.name, "_cmd_ack"}, 16'(ack));
        if (t.cmd_ack) exp_code = t.cmd;
        chk({t.name, "_cmd_valid_pulses"}, 32'(cv_cnt - cv0), 32'(t.cmd_ack));
        chk({t.name, "_cmd_code"}, 32'(cmd_code), 32'(exp_code));
        i2c_start();
        sb_q.push_back(16'(t.rd_ack));
        write_byte(8'h81, ack);
        sb_check({t.name, "_addr_r_ack"}, 16'(ack));
        if (t.rd_ack) begin
            // Snapshot already taken; these values must not appear on the bus
            temp_data = ~t.temp;
            humi_data = ~t.humi;
            sb_q.push_back(16'(t.word[15:8]));
            sb_q.push_back(16'(t.word[7:0]));
            read_byte(t.m_ack_msb, b, gap);
            sb_check({t.name, "_msb"}, 16'(b));
            chk_range({t.name, "_stretch_clks"}, gap, 1000, 1010);
            v0 = sda_viol;
            watch = !t.m_ack_msb;
            read_byte(1'b0, b, gap);
            watch = 1'b0;
            sb_check({t.name, "_lsb"}, 16'(b));
            if (!t.m_ack_msb) chk({t.name, "_sda_released"}, 32'(sda_viol - v0), 32'd0);
        end
        i2c_stop();
        wait_clk(5);
        chk({t.name, "_busy_after_stop"}, 32'(busy), 32'd0);
    endtask

    initial begin
        bit         ack;
        int         v0;

        vecs[0] = '{"temp",   8'hE3, 16'h6A3C, 16'h1111, 16'h6A3C, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{"humi",   8'hE5, 16'h5555, 16'h8F12, 16'h8F12, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{"badcmd", 8'hAA, 16'h2222, 16'h3333, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{"mnack",  8'hE3, 16'hC0FE, 16'h4444, 16'hC0FF, 1'b1, 1'b1, 1'b0};

        wait_clk(3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_cmd_code", 32'(cmd_code), 32'h00);
        chk("rst_scl", 32'(SCL), 32'd1);
        chk("rst_sda", 32'(SDA), 32'd1);
        rst_n = 1'b1;
        wait_clk(5);
        chk("idle_busy", 32'(busy), 32'd0);

        for (int v = 0; v < 4; v++) run_vec(vecs[v]);

        // Wrong address: no ACK and SDA left alone until STOP
        v0 = sda_viol;
        watch = 1'b1;
        i2c_start();
        sb_q.push_back(16'd0);
        write_byte(8'h82, ack);
        sb_check("badaddr_ack", 16'(ack));
        sb_q.push_back(16'd0);
        write_byte(8'hFF, ack);
        sb_check("badaddr_data_ack", 16'(ack));
        watch = 1'b0;
        chk("badaddr_sda_released", 32'(sda_viol - v0), 32'd0);
        chk("badaddr_busy", 32'(busy), 32'd1);
        i2c_stop();
        wait_clk(5);
        chk("badaddr_busy_after_stop", 32'(busy), 32'd0);

        // Pending from the aborted read survives STOPs; reset in the stretch
        temp_data = 16'h1234;
        i2c_start();
        sb_q.push_back(16'd1);
        write_byte(8'h81, ack);
        sb_check("rst_test_addr_r_ack", 16'(ack));
        m_scl_rel = 1'b1;
        wait_clk(100);
        chk("stretch_scl_low", 32'(SCL), 32'd0);
        chk("stretch_bit15", 32'(SDA), 32'd0);
        chk("stretch_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_scl", 32'(SCL), 32'd1);
        chk("midrst_sda", 32'(SDA), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("midrst_cmd_code", 32'(cmd_code), 32'h00);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(20);
        chk("postrst_busy", 32'(busy), 32'd0);
        i2c_start();
        sb_q.push_back(16'd0);
        write_byte(8'h81, ack);
        sb_check("postrst_read_nack", 16'(ack));
        i2c_stop();
        wait_clk(5);
        chk("postrst_busy_after_stop", 32'(busy), 32'd0);
        chk("sb_queue_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
